// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory bus port between instruction fetch and the
//               EX/MEM data requester, one transaction at a time.
//               Optional round-robin arbitration: define MEM_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              data_rd_en,
  input  logic              data_wr_en,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [1:0]        data_size,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [1:0]        bus_size,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_busy  = 2'd1;
  localparam logic [1:0] c_st_resp  = 2'd2;

  localparam logic [1:0] c_own_none = 2'd0;
  localparam logic [1:0] c_own_if   = 2'd1;
  localparam logic [1:0] c_own_data = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_owner;
  logic [1:0]        w_owner_nxt;
  logic              r_flush_pend;
  logic              w_data_pend;
  logic              w_if_pend;
  logic              w_grant_data;
  logic              w_grant_if;
  logic              w_if_kill;
  logic              w_bus_we_nxt;
  logic [ADDR_W-1:0] w_bus_addr_nxt;
  logic [DATA_W-1:0] w_bus_wdata_nxt;
  logic [1:0]        w_bus_size_nxt;
  logic              w_if_ack_nxt;
  logic [DATA_W-1:0] w_if_rdata_nxt;
  logic              w_data_ack_nxt;
  logic [DATA_W-1:0] w_data_rdata_nxt;

  assign w_data_pend = data_rd_en | data_wr_en;
  assign w_if_pend   = if_req & ~if_flush;

`ifdef MEM_ARB_RR_EN
  logic r_last_data;  // 1 when the most recent grant went to the data side

  assign w_grant_data = w_data_pend & (~w_if_pend | ~r_last_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_data <= 1'b0;
    end else if (r_state == c_st_idle) begin
      if (w_grant_data)
        r_last_data <= 1'b1;
      else if (w_grant_if)
        r_last_data <= 1'b0;
    end
  end
`else
  assign w_grant_data = w_data_pend;
`endif

  assign w_grant_if = w_if_pend & ~w_grant_data;
  assign w_if_kill  = r_flush_pend | if_flush;

  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = w_data_pend & ~data_ack;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_owner      <= c_own_none;
      r_flush_pend <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_size     <= 2'd0;
      if_ack       <= 1'b0;
      if_rdata     <= '0;
      data_ack     <= 1'b0;
      data_rdata   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      bus_req    <= (w_state_nxt == c_st_busy);
      bus_we     <= w_bus_we_nxt;
      bus_addr   <= w_bus_addr_nxt;
      bus_wdata  <= w_bus_wdata_nxt;
      bus_size   <= w_bus_size_nxt;
      if_ack     <= w_if_ack_nxt;
      if_rdata   <= w_if_rdata_nxt;
      data_ack   <= w_data_ack_nxt;
      data_rdata <= w_data_rdata_nxt;
      if (w_state_nxt == c_st_idle)
        r_flush_pend <= 1'b0;
      else if ((r_state == c_st_busy) && (r_owner == c_own_if) && if_flush)
        r_flush_pend <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_grant_data || w_grant_if) w_state_nxt = c_st_busy;
      c_st_busy: if (bus_ack) w_state_nxt = c_st_resp;
      c_st_resp: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Bus fields hold their captured values except at grant time
  always_comb begin
    w_owner_nxt      = r_owner;
    w_bus_we_nxt     = bus_we;
    w_bus_addr_nxt   = bus_addr;
    w_bus_wdata_nxt  = bus_wdata;
    w_bus_size_nxt   = bus_size;
    w_if_ack_nxt     = 1'b0;
    w_if_rdata_nxt   = '0;
    w_data_ack_nxt   = 1'b0;
    w_data_rdata_nxt = '0;
    case (r_state)
      c_st_idle: begin
        w_owner_nxt = c_own_none;
        if (w_grant_data) begin
          w_owner_nxt     = c_own_data;
          w_bus_we_nxt    = data_wr_en;
          w_bus_addr_nxt  = data_addr;
          w_bus_wdata_nxt = data_wdata;
          w_bus_size_nxt  = data_size;
        end else if (w_grant_if) begin
          w_owner_nxt     = c_own_if;
          w_bus_we_nxt    = 1'b0;
          w_bus_addr_nxt  = if_addr;
          w_bus_wdata_nxt = '0;
          w_bus_size_nxt  = 2'd3;
        end
      end
      c_st_busy: begin
        if (bus_ack) begin
          if (r_owner == c_own_data) begin
            w_data_ack_nxt   = 1'b1;
            w_data_rdata_nxt = bus_rdata;
          end else if ((r_owner == c_own_if) && !w_if_kill) begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = bus_rdata;
          end
        end
      end
      default: w_owner_nxt = c_own_none;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ack, if_stall;
  logic [63:0] if_addr, if_rdata;
  logic        data_rd_en, data_wr_en, data_ack, mem_stall;
  logic [63:0] data_addr, data_wdata, data_rdata;
  logic [1:0]  data_size;
  logic        bus_req, bus_we, bus_ack;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  bus_size;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit c_rr = 1'b1;
`else
  localparam bit c_rr = 1'b0;
`endif

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_size(data_size),
    .data_ack(data_ack), .data_rdata(data_rdata), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_size(bus_size),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; if_flush = 0;
    data_rd_en = 0; data_wr_en = 0; data_addr = '0; data_wdata = '0; data_size = 2'd0;
    bus_ack = 0; bus_rdata = '0;

    // ---- reset ----
    @(negedge clk); @(negedge clk); #1;
    chk("rst_bus_req", {63'd0, bus_req}, 64'd0);
    chk("rst_bus_fields", {bus_we, bus_size, bus_addr[60:0] | bus_wdata[60:0]}, 64'd0);
    chk("rst_acks", {62'd0, if_ack, data_ack}, 64'd0);
    chk("rst_rdata", if_rdata | data_rdata, 64'd0);

    // ---- fetch after reset, bus_ack on 3rd BUSY cycle ----
    @(negedge clk); rst = 0; if_req = 1; if_addr = 64'h8000_0000; #1;
    chk("f_stall_c0", {63'd0, if_stall}, 64'd1);
    chk("f_idle_noreq", {63'd0, bus_req}, 64'd0);
    @(negedge clk); #1;
    chk("f_bus_req", {63'd0, bus_req}, 64'd1);
    chk("f_bus_addr", bus_addr, 64'h8000_0000);
    chk("f_bus_we_size", {61'd0, bus_we, bus_size}, 64'd3);
    @(negedge clk);
    @(negedge clk); bus_ack = 1; bus_rdata = 64'h0000_0013_0010_0093; #1;
    chk("f_no_early_ack", {63'd0, if_ack}, 64'd0);
    chk("f_stall_busy", {63'd0, if_stall}, 64'd1);
    @(negedge clk); bus_ack = 0; bus_rdata = '0; #1;
    chk("f_ack", {63'd0, if_ack}, 64'd1);
    chk("f_rdata", if_rdata, 64'h0000_0013_0010_0093);
    chk("f_stall_resp", {63'd0, if_stall}, 64'd0);
    chk("f_bus_req_drop", {63'd0, bus_req}, 64'd0);
    if_req = 0;
    @(negedge clk); #1;
    chk("f_ack_clr", {63'd0, if_ack}, 64'd0);
    chk("f_rdata_clr", if_rdata, 64'd0);

    // ---- store, bus_ack on 2nd BUSY cycle ----
    @(negedge clk); data_wr_en = 1; data_addr = 64'h1008; data_wdata = 64'hAB; data_size = 2'd0; #1;
    chk("s_stall_c0", {63'd0, mem_stall}, 64'd1);
    @(negedge clk); #1;
    chk("s_bus_req", {63'd0, bus_req}, 64'd1);
    chk("s_bus_addr", bus_addr, 64'h1008);
    chk("s_bus_wdata", bus_wdata, 64'hAB);
    chk("s_bus_we_size", {61'd0, bus_we, bus_size}, 64'd4);
    chk("s_stall_c1", {63'd0, mem_stall}, 64'd1);
    @(negedge clk); bus_ack = 1; #1;
    chk("s_stall_c2", {63'd0, mem_stall}, 64'd1);
    @(negedge clk); bus_ack = 0; #1;
    chk("s_ack_c3", {63'd0, data_ack}, 64'd1);
    chk("s_stall_c3", {63'd0, mem_stall}, 64'd0);
    data_wr_en = 0;
    @(negedge clk); #1;
    chk("s_ack_clr", {63'd0, data_ack}, 64'd0);

    // ---- contention: fetch and load together ----
    @(negedge clk); if_req = 1; if_addr = 64'h2000;
    data_rd_en = 1; data_addr = 64'h3000; data_size = 2'd3; #1;
    @(negedge clk); bus_ack = 1; bus_rdata = 64'h1111; #1;
    chk("c_first_addr", bus_addr, c_rr ? 64'h2000 : 64'h3000);
    chk("c_first_we", {63'd0, bus_we}, 64'd0);
    @(negedge clk); bus_ack = 0; bus_rdata = '0; #1;
    chk("c_first_acks", {62'd0, if_ack, data_ack}, c_rr ? 64'd2 : 64'd1);
    chk("c_first_rdata", c_rr ? if_rdata : data_rdata, 64'h1111);
    if (c_rr) if_req = 0; else data_rd_en = 0;
    @(negedge clk); #1;
    chk("c_idle_gap", {63'd0, bus_req}, 64'd0);
    @(negedge clk); bus_ack = 1; bus_rdata = 64'h2222; #1;
    chk("c_second_req", {63'd0, bus_req}, 64'd1);
    chk("c_second_addr", bus_addr, c_rr ? 64'h3000 : 64'h2000);
    @(negedge clk); bus_ack = 0; bus_rdata = '0; #1;
    chk("c_second_acks", {62'd0, if_ack, data_ack}, c_rr ? 64'd1 : 64'd2);
    chk("c_second_rdata", c_rr ? data_rdata : if_rdata, 64'h2222);
    if_req = 0; data_rd_en = 0;

    // ---- flush one cycle before bus_ack ----
    @(negedge clk); if_req = 1; if_addr = 64'h4000; #1;
    @(negedge clk); #1;
    chk("fl_bus_addr", bus_addr, 64'h4000);
    @(negedge clk); if_flush = 1; #1;
    @(negedge clk); if_flush = 0; bus_ack = 1; bus_rdata = 64'hDEAD; #1;
    @(negedge clk); bus_ack = 0; bus_rdata = '0; #1;
    chk("fl_no_ack", {63'd0, if_ack}, 64'd0);
    chk("fl_rdata_zero", if_rdata, 64'd0);
    chk("fl_bus_req_drop", {63'd0, bus_req}, 64'd0);
    if_addr = 64'h5000;
    @(negedge clk); #1;
    chk("fl_idle", {63'd0, bus_req}, 64'd0);
    @(negedge clk); bus_ack = 1; bus_rdata = 64'hBEEF; #1;
    chk("fl_new_req", {63'd0, bus_req}, 64'd1);
    chk("fl_new_addr", bus_addr, 64'h5000);
    @(negedge clk); bus_ack = 0; bus_rdata = '0; #1;
    chk("fl_new_ack", {63'd0, if_ack}, 64'd1);
    chk("fl_new_rdata", if_rdata, 64'hBEEF);
    if_req = 0;

    // ---- reset in BUSY, then stray bus_ack ----
    @(negedge clk); data_rd_en = 1; data_addr = 64'h6000; data_size = 2'd2; #1;
    @(negedge clk); #1;
    chk("r_busy", {63'd0, bus_req}, 64'd1);
    rst = 1;
    @(negedge clk); rst = 0; data_rd_en = 0; bus_ack = 1; bus_rdata = 64'h7777; #1;
    chk("r_bus_req_drop", {63'd0, bus_req}, 64'd0);
    chk("r_bus_addr_clr", bus_addr, 64'd0);
    @(negedge clk); bus_ack = 0; bus_rdata = '0; #1;
    chk("r_stray_acks", {62'd0, if_ack, data_ack}, 64'd0);
    chk("r_stray_rdata", data_rdata, 64'd0);
    chk("r_stay_idle", {63'd0, bus_req}, 64'd0);

    // ---- both enables: treated as a write ----
    @(negedge clk); data_rd_en = 1; data_wr_en = 1; data_addr = 64'h7000;
    data_wdata = 64'h55; data_size = 2'd2; #1;
    @(negedge clk); bus_ack = 1; #1;
    chk("d_bus_we", {63'd0, bus_we}, 64'd1);
    chk("d_bus_size", {62'd0, bus_size}, 64'd2);
    chk("d_bus_wdata", bus_wdata, 64'h55);
    @(negedge clk); bus_ack = 0; #1;
    chk("d_ack", {63'd0, data_ack}, 64'd1);
    data_rd_en = 0; data_wr_en = 0;
    @(negedge clk); #1;
    chk("d_ack_clr", {63'd0, data_ack}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
